// File: rtl/rv32_bus_master_arb_pkg.sv
// rv32_bus_master_arb_pkg: shared grant-state encoding and bus constants.
package rv32_bus_master_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hdeadbeef;

endpackage

// File: rtl/rv32_bus_master_arb_watchdog.sv
// bus_watchdog: counts stalled cycles of one transaction and pulses expire on the last allowed one.
module bus_watchdog #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    if (CYCLES == 0) begin : g_off
        assign expire = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(CYCLES + 1);
        logic [CW-1:0] count;
        always_ff @(posedge clk) begin
            if (reset || clr)
                count <= '0;
            else if (en)
                count <= count + 1'b1;
        end
        assign expire = en && (count == CW'(CYCLES - 1));
    end

endmodule

// File: rtl/rv32_bus_master_arb.sv
// rv32_bus_master_arb: round-robin two-master arbiter for the native valid/ready bus with a transaction watchdog.
module rv32_bus_master_arb
    import rv32_bus_master_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        err_timeout,
    input  logic        err_clear
);

    arb_state_t state, state_nxt;
    logic       last_grant, last_grant_nxt;
    logic       granted, sel1, act_valid, wd_en, expire, fin;

    bus_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (!granted),
        .en     (wd_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            err_timeout <= expire ? 1'b1 : (err_clear ? 1'b0 : err_timeout);
        end
    end

    always_comb begin
        granted        = state != IDLE;
        sel1           = state == GRANT1;
        act_valid      = sel1 ? m1_valid : m0_valid;
        s_valid        = granted && act_valid;
        s_addr         = sel1 ? m1_addr : m0_addr;
        s_wdata        = sel1 ? m1_wdata : m0_wdata;
        s_wstrb        = sel1 ? m1_wstrb : m0_wstrb;
        wd_en          = s_valid && !s_ready;
        // s_ready outranks a simultaneous watchdog expiry
        fin            = (s_valid && s_ready) || expire;
        m0_ready       = (state == GRANT0) && fin;
        m1_ready       = sel1 && fin;
        m0_rdata       = (state == GRANT0) && expire ? TIMEOUT_RDATA : s_rdata;
        m1_rdata       = sel1 && expire ? TIMEOUT_RDATA : s_rdata;
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (!granted)
            state_nxt = m0_valid && (!m1_valid || last_grant) ? GRANT0 : (m1_valid ? GRANT1 : IDLE);
        else if (fin || !act_valid) begin
            state_nxt      = IDLE;
            last_grant_nxt = sel1;
        end
    end

endmodule
